// File: rtl/coherent_dcache.sv
// Direct-mapped, write-back, MSI-coherent L1 data cache with 2-word blocks.
// Serves datapath hits combinationally, fills/writes back over dREN/dWEN/dwait and answers snoops.
module coherent_dcache #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        cctrans,
    output logic        ccwrite,
    input  logic        dwait,
    input  logic [31:0] dload,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr
);
    localparam int unsigned IdxW = $clog2(SETS);
    localparam int unsigned TagW = 32 - 3 - IdxW;
    localparam logic [IdxW:0] FlushEnd = (IdxW + 1)'(SETS);

    typedef enum logic [3:0] {
        StIdle, StWb1, StWb2, StRd1, StRd2, StFlush, StFwb1, StFwb2, StDone
    } state_t;

    state_t            state_q, state_d;
    logic [SETS-1:0]   valid_q, dirty_q;
    logic [TagW-1:0]   tag_q  [SETS];
    logic [31:0]       data_q [SETS][2];
    logic [31:0]       fill_q;
    logic [IdxW:0]     fcnt_q;
    logic              ccwait_q, inv_pend_q;
    logic [31:0]       snp_addr_q;

    logic [IdxW-1:0]   req_idx, snp_idx, se_idx, fidx;
    logic [TagW-1:0]   req_tag, snp_tag, se_tag;
    logic              req_off, req_hit, snp_hit, se_hit, snoop_end, stall;
    logic              do_store, fill_lat, install, wb_clean, flush_clean, fcnt_inc;
    logic              unused;

    assign unused    = ^{dmemaddr[1:0], ccsnoopaddr[1:0], snp_addr_q[2:0]};
    assign req_idx   = dmemaddr[2+IdxW:3];
    assign req_tag   = dmemaddr[31:3+IdxW];
    assign req_off   = dmemaddr[2];
    assign snp_idx   = ccsnoopaddr[2+IdxW:3];
    assign snp_tag   = ccsnoopaddr[31:3+IdxW];
    assign se_idx    = snp_addr_q[2+IdxW:3];
    assign se_tag    = snp_addr_q[31:3+IdxW];
    assign fidx      = fcnt_q[IdxW-1:0];
    assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign snp_hit   = valid_q[snp_idx] && (tag_q[snp_idx] == snp_tag);
    assign se_hit    = valid_q[se_idx] && (tag_q[se_idx] == se_tag);
    // The cycle after ccwait drops applies the snoop's state change, so the FSM stays frozen
    assign snoop_end = ccwait_q && !ccwait;
    assign stall     = ccwait || snoop_end;

    always_comb begin
        state_d     = state_q;
        dhit        = 1'b0;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        daddr       = '0;
        dstore      = '0;
        cctrans     = 1'b0;
        ccwrite     = 1'b0;
        flushed     = 1'b0;
        do_store    = 1'b0;
        fill_lat    = 1'b0;
        install     = 1'b0;
        wb_clean    = 1'b0;
        flush_clean = 1'b0;
        fcnt_inc    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (halt) begin
                    state_d = StFlush;
                end else if (dmemREN || dmemWEN) begin
                    if (req_hit && (dmemREN || dirty_q[req_idx])) begin
                        dhit     = 1'b1;
                        do_store = dmemWEN;
                    end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = StWb1;
                    end else begin
                        state_d = StRd1;
                    end
                end
            end
            StWb1: begin
                if (!(valid_q[req_idx] && dirty_q[req_idx])) begin
                    state_d = StRd1;
                end else begin
                    cctrans = 1'b1;
                    dWEN    = 1'b1;
                    daddr   = {tag_q[req_idx], req_idx, 1'b0, 2'b00};
                    dstore  = data_q[req_idx][0];
                    if (!dwait) state_d = StWb2;
                end
            end
            StWb2: begin
                cctrans = 1'b1;
                dWEN    = 1'b1;
                daddr   = {tag_q[req_idx], req_idx, 1'b1, 2'b00};
                dstore  = data_q[req_idx][1];
                if (!dwait) begin
                    wb_clean = 1'b1;
                    state_d  = StRd1;
                end
            end
            StRd1: begin
                cctrans = 1'b1;
                dREN    = 1'b1;
                ccwrite = dmemWEN;
                daddr   = {req_tag, req_idx, 1'b0, 2'b00};
                if (!dwait) begin
                    fill_lat = 1'b1;
                    state_d  = StRd2;
                end
            end
            StRd2: begin
                cctrans = 1'b1;
                dREN    = 1'b1;
                ccwrite = dmemWEN;
                daddr   = {req_tag, req_idx, 1'b1, 2'b00};
                if (!dwait) begin
                    install = 1'b1;
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (fcnt_q == FlushEnd) begin
                    state_d = StDone;
                end else if (valid_q[fidx] && dirty_q[fidx]) begin
                    state_d = StFwb1;
                end else begin
                    fcnt_inc = 1'b1;
                end
            end
            StFwb1: begin
                if (!(valid_q[fidx] && dirty_q[fidx])) begin
                    fcnt_inc = 1'b1;
                    state_d  = StFlush;
                end else begin
                    cctrans = 1'b1;
                    dWEN    = 1'b1;
                    daddr   = {tag_q[fidx], fidx, 1'b0, 2'b00};
                    dstore  = data_q[fidx][0];
                    if (!dwait) state_d = StFwb2;
                end
            end
            StFwb2: begin
                cctrans = 1'b1;
                dWEN    = 1'b1;
                daddr   = {tag_q[fidx], fidx, 1'b1, 2'b00};
                dstore  = data_q[fidx][1];
                if (!dwait) begin
                    flush_clean = 1'b1;
                    fcnt_inc    = 1'b1;
                    state_d     = StFlush;
                end
            end
            StDone: flushed = 1'b1;
            default: state_d = StIdle;
        endcase
        if (stall) begin
            state_d     = state_q;
            dhit        = 1'b0;
            dREN        = 1'b0;
            dWEN        = 1'b0;
            cctrans     = 1'b0;
            ccwrite     = 1'b0;
            do_store    = 1'b0;
            fill_lat    = 1'b0;
            install     = 1'b0;
            wb_clean    = 1'b0;
            flush_clean = 1'b0;
            fcnt_inc    = 1'b0;
        end
        if (ccwait) begin
            cctrans = 1'b1;
            ccwrite = snp_hit && dirty_q[snp_idx];
            dstore  = data_q[snp_idx][ccsnoopaddr[2]];
        end
        dmemload = dhit ? data_q[req_idx][req_off] : '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            dirty_q    <= '0;
            fcnt_q     <= '0;
            fill_q     <= '0;
            ccwait_q   <= 1'b0;
            inv_pend_q <= 1'b0;
            snp_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            ccwait_q <= ccwait;
            if (ccwait) snp_addr_q <= ccsnoopaddr;
            if (ccwait && ccinv && snp_hit) inv_pend_q <= 1'b1;
            if (snoop_end) begin
                inv_pend_q <= 1'b0;
                if (se_hit) begin
                    if (inv_pend_q) valid_q[se_idx] <= 1'b0;
                    else            dirty_q[se_idx] <= 1'b0;
                end
            end
            if (fill_lat) fill_q <= dload;
            if (install) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= dmemWEN;
            end
            if (wb_clean)    dirty_q[req_idx] <= 1'b0;
            if (flush_clean) dirty_q[fidx] <= 1'b0;
            if (fcnt_inc)    fcnt_q <= fcnt_q + 1'b1;
        end
    end

    // Tags and data need no reset; valid bits gate every use
    always_ff @(posedge CLK) begin
        if (install) begin
            tag_q[req_idx]     <= req_tag;
            data_q[req_idx][0] <= fill_q;
            data_q[req_idx][1] <= dload;
        end
        if (do_store) data_q[req_idx][req_off] <= dmemstore;
    end

endmodule

// File: tb/tb_coherent_dcache.sv
// Scoreboard bench for coherent_dcache: directed requests push expected hits and memory words,
// a negedge monitor pops and compares whatever the cache presents.
module tb_coherent_dcache;
    logic        CLK, nRST;
    logic        dmemREN, dmemWEN, halt, dhit, flushed;
    logic [31:0] dmemaddr, dmemstore, dmemload;
    logic        dREN, dWEN, cctrans, ccwrite, dwait, ccwait, ccinv;
    logic [31:0] daddr, dstore, dload, ccsnoopaddr;

    coherent_dcache dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .cctrans(cctrans),
        .ccwrite(ccwrite), .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr)
    );

    typedef struct packed {logic wr; logic ccw; logic [31:0] addr; logic [31:0] data;} mexp_t;
    typedef struct packed {logic st; logic [31:0] data;} hexp_t;

    mexp_t       memq[$];
    hexp_t       hitq[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0, n_fail = 0, wr_cnt = 0, lat;
    logic        hold_mem = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: one wait cycle, then one done cycle per word
    always @(posedge CLK) begin
        dwait <= !((dREN || dWEN) && dwait && !hold_mem);
        dload <= mem_rd(daddr);
    end

    always @(negedge CLK) begin
        if (nRST && dhit) begin
            if (hitq.size() == 0) begin
                chk("unexpected_dhit", dmemaddr, 32'hFFFF_FFFF);
            end else begin
                hexp_t h;
                h = hitq.pop_front();
                chk("hit_kind", {31'd0, dmemWEN}, {31'd0, h.st});
                if (!h.st) chk("hit_load", dmemload, h.data);
            end
        end
        if (nRST && !ccwait && (dREN || dWEN) && !dwait) begin
            if (memq.size() == 0) begin
                chk("unexpected_mem_word", daddr, 32'hFFFF_FFFF);
            end else begin
                mexp_t m;
                m = memq.pop_front();
                chk("mem_dir", {31'd0, dWEN}, {31'd0, m.wr});
                chk("mem_addr", daddr, m.addr);
                if (m.wr) begin
                    chk("wb_data", dstore, m.data);
                    mem[daddr] = dstore;
                    wr_cnt++;
                end else begin
                    chk("rd_ccwrite", {31'd0, ccwrite}, {31'd0, m.ccw});
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int l);
        dmemREN = !we; dmemWEN = we; dmemaddr = a; dmemstore = d;
        l = 0;
        forever begin
            @(negedge CLK);
            if (dhit) break;
            l++;
            if (l > 300) begin
                chk("req_timeout", a, 32'hFFFF_FFFF);
                break;
            end
        end
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    task automatic push_rd(input logic ccw, input logic [31:0] a);
        memq.push_back('{wr: 1'b0, ccw: ccw, addr: a, data: 32'h0});
        memq.push_back('{wr: 1'b0, ccw: ccw, addr: a + 32'd4, data: 32'h0});
    endtask

    task automatic snoop(input logic [31:0] a, input logic inv, input logic exp_ccw,
                         input logic [31:0] exp_d);
        ccwait = 1'b1; ccsnoopaddr = a; ccinv = inv;
        @(negedge CLK);
        chk("snp_cctrans", {31'd0, cctrans}, 32'd1);
        chk("snp_ccwrite", {31'd0, ccwrite}, {31'd0, exp_ccw});
        chk("snp_own_ren", {31'd0, dREN}, 32'd0);
        if (exp_ccw) chk("snp_dstore", dstore, exp_d);
        @(posedge CLK); #1;
        ccwait = 1'b0; ccinv = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        nRST = 1'b0; dmemREN = 0; dmemWEN = 0; dmemaddr = 0; dmemstore = 0; halt = 0;
        ccwait = 0; ccinv = 0; ccsnoopaddr = 0; dwait = 1'b1; dload = 0;
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        chk("rst_dhit", {31'd0, dhit}, 32'd0);
        chk("rst_dren", {31'd0, dREN}, 32'd0);
        chk("rst_dwen", {31'd0, dWEN}, 32'd0);
        chk("rst_cctrans", {31'd0, cctrans}, 32'd0);
        chk("rst_flushed", {31'd0, flushed}, 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        @(posedge CLK); #1;

        // clean load miss, then same-block hit
        push_rd(1'b0, 32'h100);
        hitq.push_back('{st: 1'b0, data: 32'h5A5A_0100});
        do_req(1'b0, 32'h100, 0, lat);
        chk("lat_miss_clean", lat, 5);
        hitq.push_back('{st: 1'b0, data: 32'h5A5A_0104});
        do_req(1'b0, 32'h104, 0, lat);
        chk("lat_hit", lat, 0);

        // store to S line refetches with write intent
        push_rd(1'b1, 32'h100);
        hitq.push_back('{st: 1'b1, data: 32'h0});
        do_req(1'b1, 32'h100, 32'hDEAD, lat);
        chk("lat_store_s", lat, 5);
        hitq.push_back('{st: 1'b0, data: 32'hDEAD});
        do_req(1'b0, 32'h100, 0, lat);

        // dirty eviction
        memq.push_back('{wr: 1'b1, ccw: 1'b0, addr: 32'h100, data: 32'hDEAD});
        memq.push_back('{wr: 1'b1, ccw: 1'b0, addr: 32'h104, data: 32'h5A5A_0104});
        push_rd(1'b0, 32'h180);
        hitq.push_back('{st: 1'b0, data: 32'h5A5A_0180});
        do_req(1'b0, 32'h180, 0, lat);
        chk("lat_miss_dirty", lat, 9);

        // snoop on M line supplies data and downgrades to S
        push_rd(1'b1, 32'h100);
        hitq.push_back('{st: 1'b1, data: 32'h0});
        do_req(1'b1, 32'h104, 32'hBEEF, lat);
        snoop(32'h104, 1'b0, 1'b1, 32'hBEEF);
        mem[32'h104] = 32'hBEEF;
        snoop(32'h100, 1'b0, 1'b0, 32'h0);
        hitq.push_back('{st: 1'b0, data: 32'hBEEF});
        do_req(1'b0, 32'h104, 0, lat);
        chk("lat_hit_after_snoop", lat, 0);

        // invalidating snoop makes the next load miss
        snoop(32'h100, 1'b1, 1'b0, 32'h0);
        push_rd(1'b0, 32'h100);
        hitq.push_back('{st: 1'b0, data: 32'hBEEF});
        do_req(1'b0, 32'h104, 0, lat);
        chk("lat_after_inv", lat, 5);

        // invalidating snoop while own RD1 is stalled
        push_rd(1'b1, 32'h100);
        hitq.push_back('{st: 1'b1, data: 32'h0});
        hold_mem = 1'b1;
        fork
            do_req(1'b1, 32'h100, 32'h1234, lat);
            begin
                repeat (3) @(posedge CLK);
                @(negedge CLK);
                chk("rd1_dren", {31'd0, dREN}, 32'd1);
                chk("rd1_ccwrite", {31'd0, ccwrite}, 32'd1);
                chk("rd1_daddr", daddr, 32'h100);
                @(posedge CLK); #1;
                snoop(32'h100, 1'b1, 1'b0, 32'h0);
                hold_mem = 1'b0;
            end
        join
        hitq.push_back('{st: 1'b0, data: 32'h1234});
        do_req(1'b0, 32'h100, 0, lat);
        chk("lat_hit_after_rd1_snoop", lat, 0);

        // leave only idx 2 and 9 dirty, then flush
        snoop(32'h100, 1'b0, 1'b1, 32'h1234);
        mem[32'h100] = 32'h1234;
        push_rd(1'b1, 32'h110);
        hitq.push_back('{st: 1'b1, data: 32'h0});
        do_req(1'b1, 32'h110, 32'h2222, lat);
        push_rd(1'b1, 32'h148);
        hitq.push_back('{st: 1'b1, data: 32'h0});
        do_req(1'b1, 32'h148, 32'h9999, lat);
        memq.push_back('{wr: 1'b1, ccw: 1'b0, addr: 32'h110, data: 32'h2222});
        memq.push_back('{wr: 1'b1, ccw: 1'b0, addr: 32'h114, data: 32'h5A5A_0114});
        memq.push_back('{wr: 1'b1, ccw: 1'b0, addr: 32'h148, data: 32'h9999});
        memq.push_back('{wr: 1'b1, ccw: 1'b0, addr: 32'h14C, data: 32'h5A5A_014C});
        wr_cnt = 0;
        halt = 1'b1;
        lat = 0;
        while (!flushed && lat < 300) begin
            @(negedge CLK);
            lat++;
        end
        chk("flushed_set", {31'd0, flushed}, 32'd1);
        repeat (5) @(negedge CLK);
        chk("flushed_held", {31'd0, flushed}, 32'd1);
        chk("done_dwen", {31'd0, dWEN}, 32'd0);
        chk("flush_words", wr_cnt, 4);
        chk("memq_drained", memq.size(), 0);
        chk("hitq_drained", hitq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
